paddle_ctrl: RTL and testbench
==============================

# paddle_ctrl

Per-player paddle motion controller, directly upstream of the ball/scoring block; one instance per player. It decodes USB keycodes into up/down requests once per frame and runs a direction state machine with a speed ramp. It drives the paddle centre (PaddleX, PaddleY) and half-height (PaddleS) that the ball block uses for hit detection. A game_over input freezes and recentres the paddle.

## Interface
- X_POS, 20: fixed paddle centre X (player 2 instance uses 620)
- Y_CENTER, 240: reset/recentre Y
- HALF_HEIGHT, 32: driven on PaddleS; the ball block treats it as half-height
- Y_MIN, 0 / Y_MAX, 479: screen limits for the paddle extent
- UP_KEY, 8'h1A (W) / DOWN_KEY, 8'h16 (S): HID keycodes
- BASE_STEP, 2: initial pixels per frame
- MAX_STEP, 8: step ceiling
- ACCEL_FRAMES, 4: frames per step increment
- frame_clk  in  1  vertical-sync frame clock; the block's only clock
- Reset  in  1  asynchronous, active-high
- keycode0, keycode1  in  8  two simultaneous keycodes from the keyboard interface
- game_over  in  1  from the ball block; freeze request
- PaddleX  out  10  constant X_POS
- PaddleY  out  10  registered paddle centre Y
- PaddleS  out  10  constant HALF_HEIGHT
- Paddle_Dir  out  2  state encoding: 00 HOLD, 01 UP, 10 DOWN, 11 FROZEN

## Operation
- Key decode (combinational):
  - up = (keycode0==UP_KEY) | (keycode1==UP_KEY); down is decoded the same way from DOWN_KEY.
  - up & down together are treated as no request.
- FSM state update, priority order:
  - game_over=1 → FROZEN.
  - FROZEN with game_over=0 → HOLD (one frame, regardless of keys).
  - Otherwise up-only → UP, down-only → DOWN, none/both → HOLD.
- Speed ramp (step_n, cnt_n computed each frame, movement uses step_n):
  - Entering UP/DOWN from any other state, including a direct reversal: step_n = BASE_STEP, cnt_n = 0.
  - Staying in the same direction: if cnt+1 == ACCEL_FRAMES then step_n = min(step+1, MAX_STEP) and cnt_n = 0; else step_n = step and cnt_n = cnt+1.
  - HOLD/FROZEN: step_n = BASE_STEP, cnt_n = 0.
- Movement (11-bit signed intermediate, no wrap):
  - UP: PaddleY ← max(PaddleY − step_n, Y_MIN + HALF_HEIGHT).
  - DOWN: PaddleY ← min(PaddleY + step_n, Y_MAX − HALF_HEIGHT).
  - A clamped move also forces step and cnt back to BASE_STEP and 0.
  - HOLD: PaddleY holds. FROZEN: PaddleY ← Y_CENTER.
- Reset values:
  - PaddleY = Y_CENTER, Paddle_Dir = HOLD, step = BASE_STEP, cnt = 0.
  - PaddleX and PaddleS are constants.

## Timing
- All state updates on posedge frame_clk; Reset acts immediately, asynchronously, including mid-ramp or while FROZEN.
- Latency: a key change is reflected in PaddleY and Paddle_Dir at the next frame_clk edge.
- A held key from rest gives steps of 2,2,2,2,3,3,3,3,4,… and saturates at 8.
- A game_over assertion recentres the paddle at the next edge. After deassertion there is one HOLD frame before keys act.
- Keycodes need no handshake; they are sampled at each edge.

## Configuration
- PADDLE_ACCEL_EN defined: speed ramp as above.
- Undefined: step is constantly BASE_STEP, and the cnt register and ramp logic are not built. FSM, clamping and freeze behave identically.

## Structure
- paddle_pkg holds:
  - the paddle_state_t enum (HOLD=2'b00, UP=2'b01, DOWN=2'b10, FROZEN=2'b11);
  - keycode constants KEY_W=8'h1A, KEY_S=8'h16, KEY_UP=8'h52, KEY_DOWN=8'h51.
- Sub-module paddle_speed_ramp contains the step/cnt registers. Its inputs are restart and advance; its output is step_n. It is instantiated only under PADDLE_ACCEL_EN.

## Test plan
- Reset, no keys for 10 frames → PaddleY=240, Paddle_Dir=00, PaddleX=20, PaddleS=32.
- Hold keycode0=8'h16 for 9 frames → PaddleY 242,244,246,248,251,254,257,260,264. With the macro undefined → 258 after 9 frames.
- Hold up from 240 for 60 frames → PaddleY clamps at 32 and never goes below. Reverse to down → the first move is +2.
- keycode0=8'h1A with keycode1=8'h16 → Paddle_Dir=00, PaddleY unchanged.
- Paddle at 300, assert game_over with up held → next edge PaddleY=240 and Dir=11. Deassert → one frame Dir=00, then UP with a step of 2.
- Assert Reset asynchronously mid-ramp (step=5) → PaddleY=240 immediately. After release, down held → first move +2.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle motion controller.
package paddle_pkg;

   localparam int unsigned COORD_W = 10;
   localparam int unsigned STEP_W  = 4;

   typedef enum logic [1:0] {
      HOLD   = 2'b00,
      UP     = 2'b01,
      DOWN   = 2'b10,
      FROZEN = 2'b11
   } paddle_state_t;

   localparam logic [7:0] KEY_W    = 8'h1A;
   localparam logic [7:0] KEY_S    = 8'h16;
   localparam logic [7:0] KEY_UP   = 8'h52;
   localparam logic [7:0] KEY_DOWN = 8'h51;

endpackage

// File: rtl/paddle_ctrl_speed_ramp.sv
// Per-frame step/cnt speed ramp for paddle movement (built only with PADDLE_ACCEL_EN).
module paddle_speed_ramp
   import paddle_pkg::*;
#(
   parameter int unsigned BASE_STEP    = 2,
   parameter int unsigned MAX_STEP     = 8,
   parameter int unsigned ACCEL_FRAMES = 4
) (
   input  logic              frame_clk,
   input  logic              Reset,
   input  logic              restart,
   input  logic              advance,
   input  logic              clear,
   output logic [STEP_W-1:0] step_n
);

   localparam int unsigned CNT_W = $clog2(ACCEL_FRAMES + 1);

   logic [STEP_W-1:0] step;
   logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;

   // Next step/cnt: restart at base, otherwise bump the step every ACCEL_FRAMES frames.
   always_comb begin
      step_n  = STEP_W'(BASE_STEP);
      cnt_n   = '0;
      cnt_inc = cnt + 1'b1;
      if (!restart && advance) begin
         if (cnt_inc == CNT_W'(ACCEL_FRAMES)) begin
            cnt_n  = '0;
            step_n = (step >= STEP_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : step + 1'b1;
         end else begin
            cnt_n  = cnt_inc;
            step_n = step;
         end
      end
   end

   // Ramp registers; a clamped move drops the ramp back to base speed.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         step <= STEP_W'(BASE_STEP);
         cnt  <= '0;
      end else if (clear) begin
         step <= STEP_W'(BASE_STEP);
         cnt  <= '0;
      end else begin
         step <= step_n;
         cnt  <= cnt_n;
      end
   end

endmodule

// File: rtl/paddle_ctrl.sv
// Per-player paddle motion controller: key decode, direction FSM, clamped movement.
// Optional speed ramp enabled by defining PADDLE_ACCEL_EN.
module paddle_ctrl
   import paddle_pkg::*;
#(
   parameter int unsigned X_POS        = 20,
   parameter int unsigned Y_CENTER     = 240,
   parameter int unsigned HALF_HEIGHT  = 32,
   parameter int unsigned Y_MIN        = 0,
   parameter int unsigned Y_MAX        = 479,
   parameter logic [7:0]  UP_KEY       = KEY_W,
   parameter logic [7:0]  DOWN_KEY     = KEY_S,
   parameter int unsigned BASE_STEP    = 2,
   parameter int unsigned MAX_STEP     = 8,
   parameter int unsigned ACCEL_FRAMES = 4
) (
   input  logic                frame_clk,
   input  logic                Reset,
   input  logic [7:0]          keycode0,
   input  logic [7:0]          keycode1,
   input  logic                game_over,
   output logic [COORD_W-1:0]  PaddleX,
   output logic [COORD_W-1:0]  PaddleY,
   output logic [COORD_W-1:0]  PaddleS,
   output logic [1:0]          Paddle_Dir
);

   localparam logic signed [COORD_W:0] Y_LO = (COORD_W+1)'(Y_MIN + HALF_HEIGHT);
   localparam logic signed [COORD_W:0] Y_HI = (COORD_W+1)'(Y_MAX - HALF_HEIGHT);

   paddle_state_t         state, state_n;
   logic [COORD_W-1:0]    y_n;
   logic [STEP_W-1:0]     step_n;
   logic                  clamp;
   logic                  up, down;
   logic signed [COORD_W:0] y_s, y_up, y_dn;

   assign PaddleX    = COORD_W'(X_POS);
   assign PaddleS    = COORD_W'(HALF_HEIGHT);
   assign Paddle_Dir = state;

   assign up   = (keycode0 == UP_KEY)   | (keycode1 == UP_KEY);
   assign down = (keycode0 == DOWN_KEY) | (keycode1 == DOWN_KEY);

   // Direction FSM next state: freeze wins, one HOLD frame after unfreeze.
   always_comb begin
      state_n = state;
      if (game_over)
         state_n = FROZEN;
      else if (state == FROZEN)
         state_n = HOLD;
      else if (up && !down)
         state_n = UP;
      else if (down && !up)
         state_n = DOWN;
      else
         state_n = HOLD;
   end

`ifdef PADDLE_ACCEL_EN
   logic advance, restart;

   assign advance = (state_n == state) && ((state_n == UP) || (state_n == DOWN));
   assign restart = !advance;

   paddle_speed_ramp #(
      .BASE_STEP    (BASE_STEP),
      .MAX_STEP     (MAX_STEP),
      .ACCEL_FRAMES (ACCEL_FRAMES)
   ) u_ramp (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .restart   (restart),
      .advance   (advance),
      .clear     (clamp),
      .step_n    (step_n)
   );
`else
   logic unused_clamp;

   assign step_n       = STEP_W'(BASE_STEP);
   assign unused_clamp = clamp;
`endif

   // Next paddle centre with clamping to the screen limits; no wraparound.
   always_comb begin
      y_n   = PaddleY;
      clamp = 1'b0;
      y_s   = signed'({1'b0, PaddleY});
      y_up  = y_s - signed'((COORD_W+1)'(step_n));
      y_dn  = y_s + signed'((COORD_W+1)'(step_n));
      case (state_n)
         UP: begin
            if (y_up < Y_LO) begin
               y_n   = COORD_W'(Y_LO);
               clamp = 1'b1;
            end else begin
               y_n = COORD_W'(y_up);
            end
         end
         DOWN: begin
            if (y_dn > Y_HI) begin
               y_n   = COORD_W'(Y_HI);
               clamp = 1'b1;
            end else begin
               y_n = COORD_W'(y_dn);
            end
         end
         FROZEN:  y_n = COORD_W'(Y_CENTER);
         default: y_n = PaddleY;
      endcase
   end

   // State and position registers.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state   <= HOLD;
         PaddleY <= COORD_W'(Y_CENTER);
      end else begin
         state   <= state_n;
         PaddleY <= y_n;
      end
   end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed, table-driven bench for paddle_ctrl (expectations follow PADDLE_ACCEL_EN).
module tb_paddle_ctrl;

   logic       frame_clk;
   logic       Reset;
   logic [7:0] keycode0, keycode1;
   logic       game_over;
   logic [9:0] PaddleX, PaddleY, PaddleS;
   logic [1:0] Paddle_Dir;

   int n_vec;
   int n_err;

   typedef struct {
      logic [7:0] kc0;
      logic [7:0] kc1;
      logic       go;
      logic [9:0] y_acc;
      logic [9:0] y_base;
      logic [1:0] dir;
   } vec_t;

   vec_t vecs[40];
   int   n_tab;

   paddle_ctrl dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .keycode0   (keycode0),
      .keycode1   (keycode1),
      .game_over  (game_over),
      .PaddleX    (PaddleX),
      .PaddleY    (PaddleY),
      .PaddleS    (PaddleS),
      .Paddle_Dir (Paddle_Dir)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [7:0] kc0, input logic [7:0] kc1, input logic go,
                      input logic [9:0] ya, input logic [9:0] yb, input logic [1:0] dir);
      vecs[n_tab] = '{kc0, kc1, go, ya, yb, dir};
      n_tab++;
   endtask

   // Apply inputs, step one frame, sample 1 time unit after the edge.
   task automatic frame(input logic [7:0] kc0, input logic [7:0] kc1, input logic go);
      keycode0  = kc0;
      keycode1  = kc1;
      game_over = go;
      @(posedge frame_clk);
      #1;
   endtask

   task automatic do_reset();
      keycode0  = 8'h00;
      keycode1  = 8'h00;
      game_over = 1'b0;
      Reset     = 1'b1;
      #2;
      Reset     = 1'b0;
   endtask

   initial begin
      int ya[9];
      logic [9:0] exp_y;
      logic [9:0] min_y;

      n_vec = 0;
      n_err = 0;
      n_tab = 0;
      ya = '{242, 244, 246, 248, 251, 254, 257, 260, 264};

      for (int i = 0; i < 10; i++) add(8'h00, 8'h00, 1'b0, 240, 240, 2'b00);
      for (int i = 0; i < 9; i++)  add(8'h16, 8'h00, 1'b0, 10'(ya[i]), 10'(242 + 2*i), 2'b10);
      add(8'h1A, 8'h16, 1'b0, 264, 258, 2'b00);
      add(8'h00, 8'h1A, 1'b0, 262, 256, 2'b01);
      add(8'h00, 8'h1A, 1'b0, 260, 254, 2'b01);
      add(8'h52, 8'h00, 1'b0, 260, 254, 2'b00);
      add(8'h16, 8'h00, 1'b1, 240, 240, 2'b11);
      add(8'h00, 8'h00, 1'b1, 240, 240, 2'b11);
      add(8'h16, 8'h00, 1'b0, 240, 240, 2'b00);
      add(8'h16, 8'h00, 1'b0, 242, 242, 2'b10);
      add(8'h00, 8'h16, 1'b0, 244, 244, 2'b10);

      keycode0  = 8'h00;
      keycode1  = 8'h00;
      game_over = 1'b0;
      Reset     = 1'b1;
      #2;
      check("reset_y", PaddleY, 10'd240);
      check("reset_dir", 10'(Paddle_Dir), 10'd0);
      check("paddle_x", PaddleX, 10'd20);
      check("paddle_s", PaddleS, 10'd32);
      @(posedge frame_clk);
      #1;
      Reset = 1'b0;

      // Table: idle, ramp down, conflict, up via keycode1, unmapped key, freeze/unfreeze.
      for (int i = 0; i < n_tab; i++) begin
         frame(vecs[i].kc0, vecs[i].kc1, vecs[i].go);
`ifdef PADDLE_ACCEL_EN
         exp_y = vecs[i].y_acc;
`else
         exp_y = vecs[i].y_base;
`endif
         check($sformatf("tab%0d_y", i), PaddleY, exp_y);
         check($sformatf("tab%0d_dir", i), 10'(Paddle_Dir), 10'(vecs[i].dir));
      end

      // Long up-hold: clamps at the top limit and never passes it; reversal starts at +2.
      do_reset();
      min_y = 10'h3FF;
      for (int i = 0; i < 120; i++) begin
         frame(8'h1A, 8'h00, 1'b0);
         if (PaddleY < min_y) min_y = PaddleY;
      end
      check("up_clamp_final", PaddleY, 10'd32);
      check("up_clamp_min", min_y, 10'd32);
      frame(8'h16, 8'h00, 1'b0);
      check("reverse_first_step", PaddleY, 10'd34);

      // Tap down from 240 to 300, then freeze with up held.
      do_reset();
      for (int i = 0; i < 30; i++) begin
         frame(8'h16, 8'h00, 1'b0);
         frame(8'h00, 8'h00, 1'b0);
      end
      check("tap_to_300", PaddleY, 10'd300);
      frame(8'h1A, 8'h00, 1'b1);
      check("freeze_y", PaddleY, 10'd240);
      check("freeze_dir", 10'(Paddle_Dir), 10'd3);
      frame(8'h1A, 8'h00, 1'b0);
      check("unfreeze_dir", 10'(Paddle_Dir), 10'd0);
      check("unfreeze_y", PaddleY, 10'd240);
      frame(8'h1A, 8'h00, 1'b0);
      check("after_hold_dir", 10'(Paddle_Dir), 10'd1);
      check("after_hold_y", PaddleY, 10'd238);

      // Asynchronous reset in the middle of a ramp.
      do_reset();
      for (int i = 0; i < 14; i++) frame(8'h16, 8'h00, 1'b0);
      #3;
      Reset = 1'b1;
      #1;
      check("async_rst_y", PaddleY, 10'd240);
      check("async_rst_dir", 10'(Paddle_Dir), 10'd0);
      #1;
      Reset = 1'b0;
      frame(8'h16, 8'h00, 1'b0);
      check("post_rst_step", PaddleY, 10'd242);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
